// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: decode-side requests in, program-memory fetch controls and
// return-stack status out.
interface fetch_sequencer_if #(
   parameter int ADDR_WIDTH  = 13,
   parameter int STACK_DEPTH = 8
);
   localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

   logic                  stall;
   logic                  irq;
   logic                  ret;
   logic                  goto_en;
   logic                  call_en;
   logic [10:0]           lit;
   logic [4:0]            pclath;
   logic                  pcl_wr;
   logic [7:0]            pcl_data;
   logic                  skip;
   logic [ADDR_WIDTH-1:0] push_addr;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_rd_en;
   logic                  mem_flush;
   logic [ADDR_WIDTH-1:0] pc;
   logic [DEPTH_W-1:0]    stack_depth;
   logic                  stack_ovf;
   logic                  stack_unf;

   modport master (
      output stall, irq, ret, goto_en, call_en, lit, pclath, pcl_wr, pcl_data, skip, push_addr,
      input  mem_addr, mem_rd_en, mem_flush, pc, stack_depth, stack_ovf, stack_unf
   );

   modport slave (
      input  stall, irq, ret, goto_en, call_en, lit, pclath, pcl_wr, pcl_data, skip, push_addr,
      output mem_addr, mem_rd_en, mem_flush, pc, stack_depth, stack_ovf, stack_unf
   );
endinterface

// File: rtl/fetch_sequencer.sv
// PIC16F-style program counter and circular return stack; chooses the next fetch
// address each cycle and flushes wrong-path instructions from the memory pipeline.
module fetch_sequencer #(
   parameter int                    ADDR_WIDTH   = 13,
   parameter int                    STACK_DEPTH  = 8,
   parameter int                    FLUSH_CYCLES = 2,
   parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR   = 13'h004
) (
   input logic               clk,
   input logic               rst,
   fetch_sequencer_if.slave  bus
);
   localparam int SP_W    = $clog2(STACK_DEPTH);
   localparam int DEPTH_W = SP_W + 1;
   localparam int FCNT_W  = $clog2(FLUSH_CYCLES + 1);
   localparam logic [FCNT_W-1:0]  FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES);
   localparam logic [DEPTH_W-1:0] DEPTH_MAX  = DEPTH_W'(STACK_DEPTH);

   logic [ADDR_WIDTH-1:0] pc_q;
   logic [SP_W-1:0]       sp_q;
   logic [DEPTH_W-1:0]    depth_q;
   logic                  ovf_q;
   logic                  unf_q;
   logic [FCNT_W-1:0]     fcnt_q;
   logic                  flush_q;
   logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

   logic [ADDR_WIDTH-1:0] pc_nxt;
   logic [SP_W-1:0]       sp_nxt;
   logic [DEPTH_W-1:0]    depth_nxt;
   logic                  ovf_nxt;
   logic                  unf_nxt;
   logic [FCNT_W-1:0]     fcnt_nxt;
   logic                  push;
   logic                  pop;
   logic                  redirect;
   logic [SP_W-1:0]       sp_dec;

   function automatic logic [DEPTH_W-1:0] depth_sat_inc(input logic [DEPTH_W-1:0] d);
      return (d == DEPTH_MAX) ? d : d + DEPTH_W'(1);
   endfunction

   function automatic logic [DEPTH_W-1:0] depth_sat_dec(input logic [DEPTH_W-1:0] d);
      return (d == '0) ? d : d - DEPTH_W'(1);
   endfunction

   assign sp_dec = sp_q - SP_W'(1);

   // Next-PC source select; the first matching request wins, the rest are dropped.
   always_comb begin
      pc_nxt   = pc_q + ADDR_WIDTH'(1);
      push     = 1'b0;
      pop      = 1'b0;
      redirect = 1'b1;
      if (bus.irq) begin
         pc_nxt = IRQ_VECTOR;
         push   = 1'b1;
      end else if (bus.ret) begin
         pc_nxt = stack_mem[sp_dec];
         pop    = 1'b1;
      end else if (bus.call_en) begin
         pc_nxt = ADDR_WIDTH'({bus.pclath[4:3], bus.lit});
         push   = 1'b1;
      end else if (bus.goto_en) begin
         pc_nxt = ADDR_WIDTH'({bus.pclath[4:3], bus.lit});
      end else if (bus.pcl_wr) begin
         pc_nxt = ADDR_WIDTH'({bus.pclath, bus.pcl_data});
      end else begin
         redirect = 1'b0;
      end
   end

   always_comb begin
      sp_nxt    = sp_q;
      depth_nxt = depth_q;
      ovf_nxt   = ovf_q;
      unf_nxt   = unf_q;
      if (push) begin
         sp_nxt    = sp_q + SP_W'(1);
         depth_nxt = depth_sat_inc(depth_q);
         ovf_nxt   = ovf_q | (depth_q == DEPTH_MAX);
      end else if (pop) begin
         sp_nxt    = sp_dec;
         depth_nxt = depth_sat_dec(depth_q);
         unf_nxt   = unf_q | (depth_q == '0);
      end
   end

   // A skip only needs one bubble, so it never shortens a flush already running.
   always_comb begin
      fcnt_nxt = (fcnt_q != '0) ? fcnt_q - FCNT_W'(1) : '0;
      if (redirect) begin
         fcnt_nxt = FLUSH_LOAD;
      end else if (bus.skip && fcnt_q <= FCNT_W'(1)) begin
         fcnt_nxt = FCNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= '0;
         sp_q    <= '0;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         fcnt_q  <= '0;
         flush_q <= 1'b0;
      end else if (!bus.stall) begin
         pc_q    <= pc_nxt;
         sp_q    <= sp_nxt;
         depth_q <= depth_nxt;
         ovf_q   <= ovf_nxt;
         unf_q   <= unf_nxt;
         fcnt_q  <= fcnt_nxt;
         flush_q <= (fcnt_nxt != '0);
      end
   end

   // Stack storage carries no reset; its contents are meaningless until pushed.
   always_ff @(posedge clk) begin
      if (!rst && !bus.stall && push) begin
         stack_mem[sp_q] <= bus.push_addr;
      end
   end

   assign bus.mem_addr    = pc_q;
   assign bus.pc          = pc_q;
   assign bus.mem_rd_en   = ~bus.stall;
   assign bus.mem_flush   = flush_q;
   assign bus.stack_depth = depth_q;
   assign bus.stack_ovf   = ovf_q;
   assign bus.stack_unf   = unf_q;
endmodule
